// File: rtl/dcmi_capture.sv
`default_nettype none
// ============================================================================
// dcmi_capture: DCMI camera capture, packs 8..14-bit pixels into 32-bit words
// and streams them through a show-ahead word FIFO.   Revision: 1.0
// ============================================================================
module dcmi_capture #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        capture_en,
  input  logic        snapshot_mode,
  input  logic        vsync_polarity,
  input  logic        hsync_polarity,
  input  logic [1:0]  data_bus_width,
  input  logic        dcmi_vsync,
  input  logic        dcmi_hsync,
  input  logic [13:0] dcmi_data,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_start,
  output logic        frame_end,
  output logic        line_end,
  output logic        overflow,
  input  logic        overflow_clr,
  output logic        capture_active,
  output logic [13:0] line_cnt,
  output logic [13:0] pixel_cnt
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [13:0] CNT_MAX = 14'h3FFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_FS = 2'd1,
    ST_FRAME   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        vsync_s1_q, hsync_s1_q;
  logic [13:0] data_s1_q;
  logic        vs_prev_q, hs_prev_q;
  logic [1:0]  width_q, width_d;
  logic [31:0] pack_q, pack_d;
  logic [1:0]  pack_cnt_q, pack_cnt_d;
  logic        wr_valid_q, wr_valid_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        wr_last_q, wr_last_d;
  logic [13:0] line_cnt_q, line_cnt_d;
  logic [13:0] pixel_cnt_q, pixel_cnt_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_end_q, frame_end_d;
  logic        line_end_q, line_end_d;
  logic        overflow_q, overflow_d;
  logic        frame_words_q, frame_words_d;
  logic        snap_done_q, snap_done_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0] mem_data_q [FIFO_DEPTH];
  logic        mem_last_q [FIFO_DEPTH];

  logic        w_vs, w_hs, w_vs_rise, w_vs_fall, w_hs_rise, w_hs_fall;
  logic [15:0] w_pix;
  logic [31:0] w_packed;
  logic [1:0]  w_pack_top;
  logic        w_force_last, w_tail_patch;
  logic [AW:0] w_fifo_cnt;
  logic        w_empty, w_full, w_rd_en, w_wr_ok, w_wr_last;
  logic [AW-1:0] w_rd_idx, w_wr_idx, w_tail_idx;

  assign w_vs      = vsync_s1_q ^ vsync_polarity;
  assign w_hs      = hsync_s1_q ^ hsync_polarity;
  assign w_vs_rise = w_vs & ~vs_prev_q;
  assign w_vs_fall = ~w_vs & vs_prev_q;
  assign w_hs_rise = w_hs & ~hs_prev_q;
  assign w_hs_fall = ~w_hs & hs_prev_q;

  always_comb begin
    w_pix = 16'd0;
    case (width_q)
      2'b00:   w_pix = {8'd0, data_s1_q[7:0]};
      2'b01:   w_pix = {6'd0, data_s1_q[9:0]};
      2'b10:   w_pix = {4'd0, data_s1_q[11:0]};
      default: w_pix = {2'd0, data_s1_q};
    endcase
    if (width_q == 2'b00) begin
      w_packed   = pack_q | ({24'd0, w_pix[7:0]} << {pack_cnt_q, 3'b000});
      w_pack_top = 2'd3;
    end else begin
      w_packed   = pack_q | ({16'd0, w_pix} << {pack_cnt_q[0], 4'b0000});
      w_pack_top = 2'd1;
    end
  end

  // A word staged on the same cycle the frame ends becomes the frame's last word.
  assign w_force_last = (state_q == ST_FRAME) && w_vs_fall && (pack_cnt_q == 2'd0);

  always_comb begin
    state_d       = state_q;
    width_d       = width_q;
    pack_d        = pack_q;
    pack_cnt_d    = pack_cnt_q;
    wr_valid_d    = 1'b0;
    wr_data_d     = wr_data_q;
    wr_last_d     = wr_last_q;
    line_cnt_d    = line_cnt_q;
    pixel_cnt_d   = pixel_cnt_q;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    line_end_d    = 1'b0;
    frame_words_d = frame_words_q | w_wr_ok;
    snap_done_d   = capture_en ? snap_done_q : 1'b0;
    w_tail_patch  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (capture_en && !snap_done_q) state_d = ST_WAIT_FS;
      end
      ST_WAIT_FS: begin
        if (w_vs_rise) begin
          state_d       = ST_FRAME;
          frame_start_d = 1'b1;
          line_cnt_d    = 14'd0;
          pixel_cnt_d   = 14'd0;
          pack_d        = 32'd0;
          pack_cnt_d    = 2'd0;
          width_d       = data_bus_width;
          frame_words_d = 1'b0;
        end
      end
      ST_FRAME: begin
        if (w_hs_rise) pixel_cnt_d = 14'd0;
        if (w_vs && w_hs) begin
          pixel_cnt_d = (pixel_cnt_d == CNT_MAX) ? CNT_MAX : pixel_cnt_d + 14'd1;
          if (pack_cnt_q == w_pack_top) begin
            wr_valid_d = 1'b1;
            wr_data_d  = w_packed;
            wr_last_d  = 1'b0;
            pack_d     = 32'd0;
            pack_cnt_d = 2'd0;
          end else begin
            pack_d     = w_packed;
            pack_cnt_d = pack_cnt_q + 2'd1;
          end
        end
        if (w_hs_fall) begin
          line_end_d = 1'b1;
          line_cnt_d = (line_cnt_q == CNT_MAX) ? CNT_MAX : line_cnt_q + 14'd1;
        end
        if (w_vs_fall) begin
          frame_end_d = 1'b1;
          if (pack_cnt_q != 2'd0) begin
            wr_valid_d = 1'b1;
            wr_data_d  = pack_q;
            wr_last_d  = 1'b1;
            pack_d     = 32'd0;
            pack_cnt_d = 2'd0;
          end else if (!wr_valid_q && frame_words_q) begin
            w_tail_patch = 1'b1;
          end
          if (snapshot_mode) snap_done_d = capture_en;
          state_d = (snapshot_mode || !capture_en) ? ST_IDLE : ST_WAIT_FS;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign w_fifo_cnt = wr_ptr_q - rd_ptr_q;
  assign w_empty    = (w_fifo_cnt == '0);
  assign w_full     = (w_fifo_cnt == FULL_CNT);
  assign w_rd_en    = ~w_empty & out_ready;
  // A full FIFO still accepts a write when a word leaves on the same edge.
  assign w_wr_ok    = wr_valid_q & (~w_full | w_rd_en);
  assign w_wr_last  = wr_last_q | w_force_last;
  assign w_rd_idx   = rd_ptr_q[AW-1:0];
  assign w_wr_idx   = wr_ptr_q[AW-1:0];
  assign w_tail_idx = wr_ptr_q[AW-1:0] - AW'(1);

  always_comb begin
    wr_ptr_d   = w_wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = w_rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    overflow_d = overflow_q;
    if (overflow_clr) overflow_d = 1'b0;
    if (wr_valid_q && w_full && !w_rd_en) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      mem_data_q[w_wr_idx] <= wr_data_q;
      mem_last_q[w_wr_idx] <= w_wr_last;
    end else if (w_tail_patch && !w_empty) begin
      mem_last_q[w_tail_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      vsync_s1_q    <= 1'b0;
      hsync_s1_q    <= 1'b0;
      data_s1_q     <= 14'd0;
      vs_prev_q     <= 1'b0;
      hs_prev_q     <= 1'b0;
      width_q       <= 2'b00;
      pack_q        <= 32'd0;
      pack_cnt_q    <= 2'd0;
      wr_valid_q    <= 1'b0;
      wr_data_q     <= 32'd0;
      wr_last_q     <= 1'b0;
      line_cnt_q    <= 14'd0;
      pixel_cnt_q   <= 14'd0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      line_end_q    <= 1'b0;
      overflow_q    <= 1'b0;
      frame_words_q <= 1'b0;
      snap_done_q   <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      vsync_s1_q    <= dcmi_vsync;
      hsync_s1_q    <= dcmi_hsync;
      data_s1_q     <= dcmi_data;
      vs_prev_q     <= w_vs;
      hs_prev_q     <= w_hs;
      width_q       <= width_d;
      pack_q        <= pack_d;
      pack_cnt_q    <= pack_cnt_d;
      wr_valid_q    <= wr_valid_d;
      wr_data_q     <= wr_data_d;
      wr_last_q     <= wr_last_d;
      line_cnt_q    <= line_cnt_d;
      pixel_cnt_q   <= pixel_cnt_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      line_end_q    <= line_end_d;
      overflow_q    <= overflow_d;
      frame_words_q <= frame_words_d;
      snap_done_q   <= snap_done_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  assign out_valid      = ~w_empty;
  assign out_data       = w_empty ? 32'd0 : mem_data_q[w_rd_idx];
  assign out_last       = w_empty ? 1'b0 : mem_last_q[w_rd_idx];
  assign frame_start    = frame_start_q;
  assign frame_end      = frame_end_q;
  assign line_end       = line_end_q;
  assign overflow       = overflow_q;
  assign capture_active = (state_q != ST_IDLE);
  assign line_cnt       = line_cnt_q;
  assign pixel_cnt      = pixel_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dcmi_capture.sv
`default_nettype none
// ============================================================================
// tb_dcmi_capture: directed self-checking bench for dcmi_capture.
// Revision: 1.0
// ============================================================================
module tb_dcmi_capture;

  logic        clk = 1'b0;
  logic        rstn;
  logic        capture_en, snapshot_mode, vpol, hpol;
  logic [1:0]  data_bus_width;
  logic        dcmi_vsync, dcmi_hsync;
  logic [13:0] dcmi_data;
  logic [31:0] out_data;
  logic        out_last, out_valid, out_ready;
  logic        frame_start, frame_end, line_end;
  logic        overflow, overflow_clr, capture_active;
  logic [13:0] line_cnt, pixel_cnt;

  int checks = 0;
  int errors = 0;
  int fs_total = 0, fe_total = 0, le_total = 0;
  logic [31:0] got_data[$];
  logic        got_last[$];
  int base, fs0, fe0, le0;

  dcmi_capture #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .capture_en(capture_en), .snapshot_mode(snapshot_mode),
    .vsync_polarity(vpol), .hsync_polarity(hpol), .data_bus_width(data_bus_width),
    .dcmi_vsync(dcmi_vsync), .dcmi_hsync(dcmi_hsync), .dcmi_data(dcmi_data),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .frame_start(frame_start), .frame_end(frame_end), .line_end(line_end),
    .overflow(overflow), .overflow_clr(overflow_clr), .capture_active(capture_active),
    .line_cnt(line_cnt), .pixel_cnt(pixel_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      got_data.push_back(out_data);
      got_last.push_back(out_last);
    end
    if (frame_start) fs_total++;
    if (frame_end)   fe_total++;
    if (line_end)    le_total++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // v/h are active levels; pins are driven through the selected polarity.
  task automatic drive(input logic v, input logic h, input logic [13:0] d);
    dcmi_vsync = v ^ vpol;
    dcmi_hsync = h ^ hpol;
    dcmi_data  = d;
    tick();
  endtask

  task automatic send_frame(input int nlines, input int ppl, input logic [13:0] first,
                            input logic [13:0] step);
    logic [13:0] d;
    d = first;
    drive(1'b1, 1'b0, 14'd0);
    drive(1'b1, 1'b0, 14'd0);
    for (int l = 0; l < nlines; l++) begin
      for (int p = 0; p < ppl; p++) begin
        drive(1'b1, 1'b1, d);
        d = d + step;
      end
      if (l != nlines - 1) begin
        drive(1'b1, 1'b0, 14'd0);
        drive(1'b1, 1'b0, 14'd0);
      end
    end
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 14'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; capture_en = 1'b0; snapshot_mode = 1'b0; vpol = 1'b0; hpol = 1'b0;
    data_bus_width = 2'b00; dcmi_vsync = 1'b0; dcmi_hsync = 1'b0; dcmi_data = 14'd0;
    out_ready = 1'b1; overflow_clr = 1'b0;
    tick(); tick(); tick();
    rstn = 1'b1;
    tick();
    chk("rst_active",   {31'd0, capture_active}, 32'd0);
    chk("rst_valid",    {31'd0, out_valid}, 32'd0);
    chk("rst_data",     out_data, 32'd0);
    chk("rst_line_cnt", {18'd0, line_cnt}, 32'd0);
    chk("rst_pix_cnt",  {18'd0, pixel_cnt}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);

    capture_en = 1'b1;
    tick();
    chk("en_active", {31'd0, capture_active}, 32'd1);

    // 8-bit, two lines of four pixels
    base = got_data.size(); fs0 = fs_total; le0 = le_total; fe0 = fe_total;
    send_frame(2, 4, 14'd1, 14'd1);
    tick(); tick();
    chk("f8_words", got_data.size() - base, 32'd2);
    if (got_data.size() >= base + 2) begin
      chk("f8_w0", got_data[base], 32'h04030201);
      chk("f8_l0", {31'd0, got_last[base]}, 32'd0);
      chk("f8_w1", got_data[base+1], 32'h08070605);
      chk("f8_l1", {31'd0, got_last[base+1]}, 32'd1);
    end
    chk("f8_line_cnt", {18'd0, line_cnt}, 32'd2);
    chk("f8_pix_cnt",  {18'd0, pixel_cnt}, 32'd4);
    chk("f8_fs", fs_total - fs0, 32'd1);
    chk("f8_le", le_total - le0, 32'd2);
    chk("f8_fe", fe_total - fe0, 32'd1);

    // 12-bit, width changed after frame start must not take effect
    base = got_data.size();
    data_bus_width = 2'b10;
    drive(1'b1, 1'b0, 14'd0);
    drive(1'b1, 1'b0, 14'd0);
    data_bus_width = 2'b00;
    drive(1'b1, 1'b1, 14'h123);
    drive(1'b1, 1'b1, 14'h456);
    drive(1'b1, 1'b1, 14'h789);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 14'd0);
    chk("f12_words", got_data.size() - base, 32'd2);
    if (got_data.size() >= base + 2) begin
      chk("f12_w0", got_data[base], 32'h04560123);
      chk("f12_l0", {31'd0, got_last[base]}, 32'd0);
      chk("f12_w1", got_data[base+1], 32'h00000789);
      chk("f12_l1", {31'd0, got_last[base+1]}, 32'd1);
    end
    chk("f12_line_cnt", {18'd0, line_cnt}, 32'd1);
    chk("f12_pix_cnt",  {18'd0, pixel_cnt}, 32'd3);

    // snapshot: first frame captured with word latency of two edges, second ignored
    snapshot_mode = 1'b1;
    base = got_data.size();
    drive(1'b1, 1'b0, 14'd0);
    drive(1'b1, 1'b0, 14'd0);
    drive(1'b1, 1'b1, 14'h11);
    drive(1'b1, 1'b1, 14'h22);
    drive(1'b1, 1'b1, 14'h33);
    drive(1'b1, 1'b1, 14'h44);
    drive(1'b0, 1'b0, 14'd0);
    chk("lat_not_yet", {31'd0, out_valid}, 32'd0);
    drive(1'b0, 1'b0, 14'd0);
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_data",  out_data, 32'h44332211);
    chk("lat_last",  {31'd0, out_last}, 32'd1);
    drive(1'b0, 1'b0, 14'd0);
    drive(1'b0, 1'b0, 14'd0);
    chk("snap_inactive", {31'd0, capture_active}, 32'd0);
    send_frame(1, 4, 14'h55, 14'h11);
    chk("snap_words", got_data.size() - base, 32'd1);
    capture_en = 1'b0;
    snapshot_mode = 1'b0;
    tick();

    // enable mid-frame skips that frame; disable mid-frame still completes it
    base = got_data.size(); fs0 = fs_total;
    drive(1'b1, 1'b0, 14'd0);
    drive(1'b1, 1'b1, 14'hA1);
    drive(1'b1, 1'b1, 14'hA2);
    capture_en = 1'b1;
    drive(1'b1, 1'b1, 14'hA3);
    drive(1'b1, 1'b1, 14'hA4);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 14'd0);
    drive(1'b1, 1'b0, 14'd0);
    drive(1'b1, 1'b0, 14'd0);
    drive(1'b1, 1'b1, 14'hB1);
    capture_en = 1'b0;
    drive(1'b1, 1'b1, 14'hB2);
    drive(1'b1, 1'b1, 14'hB3);
    drive(1'b1, 1'b1, 14'hB4);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 14'd0);
    chk("mid_words", got_data.size() - base, 32'd1);
    if (got_data.size() >= base + 1) chk("mid_w0", got_data[base], 32'hB4B3B2B1);
    chk("mid_fs", fs_total - fs0, 32'd1);
    chk("mid_inactive", {31'd0, capture_active}, 32'd0);

    // overflow with a stalled consumer
    capture_en = 1'b1;
    out_ready = 1'b0;
    tick();
    send_frame(1, 24, 14'd1, 14'd1);
    chk("ovf_set",   {31'd0, overflow}, 32'd1);
    chk("ovf_valid", {31'd0, out_valid}, 32'd1);
    chk("ovf_head",  out_data, 32'h04030201);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("ovf_clr", {31'd0, overflow}, 32'd0);
    base = got_data.size();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("ovf_words", got_data.size() - base, 32'd4);
    if (got_data.size() >= base + 4) begin
      chk("ovf_first",  got_data[base], 32'h04030201);
      chk("ovf_fourth", got_data[base+3], 32'h100F0E0D);
    end

    // reset mid-frame with a buffered word, then inverted polarities
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 14'd0);
    drive(1'b1, 1'b0, 14'd0);
    for (int p = 1; p <= 4; p++) drive(1'b1, 1'b1, 14'(p));
    drive(1'b1, 1'b0, 14'd0);
    drive(1'b1, 1'b0, 14'd0);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("arst_valid",  {31'd0, out_valid}, 32'd0);
    chk("arst_active", {31'd0, capture_active}, 32'd0);
    chk("arst_line",   {18'd0, line_cnt}, 32'd0);
    chk("arst_pix",    {18'd0, pixel_cnt}, 32'd0);
    vpol = 1'b1; hpol = 1'b1;
    dcmi_vsync = 1'b1; dcmi_hsync = 1'b1; dcmi_data = 14'd0;
    tick(); tick();
    rstn = 1'b1;
    out_ready = 1'b1;
    tick(); tick(); tick();
    base = got_data.size(); fs0 = fs_total; le0 = le_total; fe0 = fe_total;
    send_frame(2, 4, 14'd1, 14'd1);
    tick(); tick();
    chk("inv_words", got_data.size() - base, 32'd2);
    if (got_data.size() >= base + 2) begin
      chk("inv_w0", got_data[base], 32'h04030201);
      chk("inv_l0", {31'd0, got_last[base]}, 32'd0);
      chk("inv_w1", got_data[base+1], 32'h08070605);
      chk("inv_l1", {31'd0, got_last[base+1]}, 32'd1);
    end
    chk("inv_line_cnt", {18'd0, line_cnt}, 32'd2);
    chk("inv_fs", fs_total - fs0, 32'd1);
    chk("inv_le", le_total - le0, 32'd2);
    chk("inv_fe", fe_total - fe0, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
